// File: rtl/sobel_stream_if.sv
// FIFO-side handshake bundle for the streaming Sobel filter.
// The master side is the filter; the slave side is the pair of FIFOs around it.
interface sobel_stream_if #(
  parameter int DWIDTH = 8
) ();
  logic              fifo_in_rd_en;
  logic [DWIDTH-1:0] fifo_in_dout;
  logic              fifo_in_empty;
  logic              fifo_out_wr_en;
  logic [DWIDTH-1:0] fifo_out_din;
  logic              fifo_out_full;

  modport master (
    output fifo_in_rd_en,
    input  fifo_in_dout,
    input  fifo_in_empty,
    output fifo_out_wr_en,
    output fifo_out_din,
    input  fifo_out_full
  );

  modport slave (
    input  fifo_in_rd_en,
    output fifo_in_dout,
    output fifo_in_empty,
    input  fifo_out_wr_en,
    input  fifo_out_din,
    output fifo_out_full
  );
endinterface

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter between two FWFT FIFOs. It produces either
// the gradient magnitude or a binary threshold map, one output per input pixel.
module sobel_stream #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8
) (
  input  logic              clock,
  input  logic              reset,
  sobel_stream_if.master    fifo,
  input  logic              mode,
  input  logic [DWIDTH-1:0] threshold,
  output logic              busy,
  output logic              frame_done
);

  localparam int W       = IMG_WIDTH;
  localparam int BUF_LEN = 2 * W + 3;
  localparam int GW      = DWIDTH + 4;

  localparam logic [11:0] X_LAST     = 12'(W - 1);
  localparam logic [11:0] Y_LAST     = 12'(IMG_HEIGHT - 1);
  localparam logic [23:0] FILL_LAST  = 24'(W + 1);
  localparam logic [23:0] PIX_LAST   = 24'(W * IMG_HEIGHT - 1);
  localparam logic [12:0] DRAIN_LAST = 13'(W + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t            state;
  logic [DWIDTH-1:0] line_buf [BUF_LEN];
  logic [11:0]       x_pos;
  logic [11:0]       y_pos;
  logic [23:0]       rd_count;
  logic [12:0]       drain_count;
  logic              mode_q;
  logic [DWIDTH-1:0] threshold_q;

  logic              rd_go;
  logic              wr_go;
  logic [DWIDTH-1:0] shift_pix;
  logic [DWIDTH-1:0] pixel_out;

  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic [GW-1:0]        abs_gx;
  logic [GW-1:0]        abs_gy;
  logic [GW-1:0]        half_sum;
  logic [DWIDTH-1:0]    mag;
  logic                 border;

  // Handshake strobes are pure functions of state and FIFO flags so that a
  // blocked cycle never moves the pipeline.
  always_comb begin
    rd_go     = 1'b0;
    wr_go     = 1'b0;
    shift_pix = '0;
    unique case (state)
      FILL: begin
        rd_go     = !fifo.fifo_in_empty;
        shift_pix = fifo.fifo_in_dout;
      end
      RUN: begin
        rd_go     = !fifo.fifo_in_empty && !fifo.fifo_out_full;
        wr_go     = rd_go;
        shift_pix = fifo.fifo_in_dout;
      end
      DRAIN: wr_go = !fifo.fifo_out_full;
      default: ;
    endcase
  end

  // Window row r, column c sits at buffer entry r*W+c; the newest pixel is the bottom-right tap.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = $signed({4'b0000, line_buf[r * W + c]});
    gx       = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy       = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    abs_gx   = gx[GW-1] ? GW'(-gx) : GW'(gx);
    abs_gy   = gy[GW-1] ? GW'(-gy) : GW'(gy);
    half_sum = GW'(({1'b0, abs_gx} + {1'b0, abs_gy}) >> 1);
    mag      = (|half_sum[GW-1:DWIDTH]) ? '1 : half_sum[DWIDTH-1:0];
    border   = (x_pos == 12'd0) || (x_pos == X_LAST) || (y_pos == 12'd0) || (y_pos == Y_LAST);
    if (border)
      pixel_out = '0;
    else if (mode_q)
      pixel_out = (mag >= threshold_q) ? '1 : '0;
    else
      pixel_out = mag;
  end

  assign fifo.fifo_in_rd_en  = rd_go;
  assign fifo.fifo_out_wr_en = wr_go;
  assign fifo.fifo_out_din   = wr_go ? pixel_out : '0;
  assign busy                = (state != IDLE);

  // Frame sequencer: IDLE clears and latches the per-frame settings, FILL primes
  // the window, RUN streams one-in/one-out, DRAIN flushes the last W+2 centres.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      x_pos       <= '0;
      y_pos       <= '0;
      rd_count    <= '0;
      drain_count <= '0;
      mode_q      <= 1'b0;
      threshold_q <= '0;
      frame_done  <= 1'b0;
      for (int i = 0; i < BUF_LEN; i++) line_buf[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        for (int i = 0; i < BUF_LEN; i++) line_buf[i] <= '0;
      end else if (rd_go || wr_go) begin
        for (int i = 0; i < BUF_LEN - 1; i++) line_buf[i] <= line_buf[i + 1];
        line_buf[BUF_LEN-1] <= shift_pix;
      end
      if (wr_go) begin
        if (x_pos == X_LAST) begin
          x_pos <= '0;
          y_pos <= y_pos + 12'd1;
        end else begin
          x_pos <= x_pos + 12'd1;
        end
      end
      unique case (state)
        IDLE: begin
          x_pos       <= '0;
          y_pos       <= '0;
          rd_count    <= '0;
          drain_count <= '0;
          mode_q      <= mode;
          threshold_q <= threshold;
          state       <= FILL;
        end
        FILL: if (rd_go) begin
          rd_count <= rd_count + 24'd1;
          if (rd_count == FILL_LAST) state <= RUN;
        end
        RUN: if (rd_go) begin
          rd_count <= rd_count + 24'd1;
          if (rd_count == PIX_LAST) state <= DRAIN;
        end
        DRAIN: if (wr_go) begin
          drain_count <= drain_count + 13'd1;
          if (drain_count == DRAIN_LAST) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on an 8x6 image: FIFO emulation with
// random stalls, and a scoreboard fed by a coordinate-based Sobel reference.
module tb_sobel_stream;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int DW   = 8;
  localparam int NPIX = W * H;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mode = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic          busy;
  logic          frame_done;

  sobel_stream_if #(.DWIDTH(DW)) fifo_bus ();

  sobel_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(DW)) dut (
    .clock      (clock),
    .reset      (reset),
    .fifo       (fifo_bus),
    .mode       (mode),
    .threshold  (threshold),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] in_q  [$];
  logic [DW-1:0] exp_q [$];
  int            img [H][W];
  int            in_stall = 0;
  int            out_stall = 0;
  int            reads = 0;
  int            writes = 0;
  int            done_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference computed straight from image coordinates.
  function automatic logic [DW-1:0] goldenPixel(input int x, input int y, input bit m, input logic [DW-1:0] th);
    int gx, gy, mag;
    if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return '0;
    gx = (img[y-1][x+1] + 2 * img[y][x+1] + img[y+1][x+1]) - (img[y-1][x-1] + 2 * img[y][x-1] + img[y+1][x-1]);
    gy = (img[y+1][x-1] + 2 * img[y+1][x] + img[y+1][x+1]) - (img[y-1][x-1] + 2 * img[y-1][x] + img[y-1][x+1]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    mag = (gx + gy) >> 1;
    if (mag > 255) mag = 255;
    if (m) return (mag >= int'(th)) ? 8'hFF : 8'h00;
    return 8'(mag);
  endfunction

  task automatic applyStimulus(input bit m, input logic [DW-1:0] th);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        in_q.push_back(8'(img[y][x]));
        exp_q.push_back(goldenPixel(x, y, m, th));
      end
  endtask

  // FIFO emulation: flags change on the falling edge, handshakes are sampled just after.
  always @(negedge clock) begin
    fifo_bus.fifo_in_dout  = (in_q.size() != 0) ? in_q[0] : 8'h00;
    fifo_bus.fifo_in_empty = (in_q.size() == 0) || ($urandom_range(99) < in_stall);
    fifo_bus.fifo_out_full = ($urandom_range(99) < out_stall);
    #1;
    if (!reset) begin
      if (frame_done) done_count++;
      if (fifo_bus.fifo_in_rd_en) begin
        checkOutput("read_while_empty", fifo_bus.fifo_in_empty, 0);
        if (in_q.size() != 0) void'(in_q.pop_front());
        reads++;
      end
      if (fifo_bus.fifo_out_wr_en) begin
        checkOutput("write_while_full", fifo_bus.fifo_out_full, 0);
        checkOutput("scoreboard_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) checkOutput($sformatf("pixel_%0d", writes), fifo_bus.fifo_out_din, exp_q.pop_front());
        writes++;
      end
    end
  end

  task automatic doReset();
    @(posedge clock);
    #2 reset = 1'b1;
    in_q.delete();
    exp_q.delete();
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_rd_en", fifo_bus.fifo_in_rd_en, 0);
    checkOutput("reset_wr_en", fifo_bus.fifo_out_wr_en, 0);
    checkOutput("reset_din", fifo_bus.fifo_out_din, 0);
    checkOutput("reset_frame_done", frame_done, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic waitFrames(input string tag, input int done_target, input int write_target);
    int cyc = 0;
    while (done_count < done_target && cyc < 5000) begin
      @(posedge clock);
      cyc++;
    end
    repeat (4) @(posedge clock);
    checkOutput({tag, "_frame_done_count"}, done_count, done_target);
    checkOutput({tag, "_write_count"}, writes, write_target);
    checkOutput({tag, "_scoreboard_left"}, exp_q.size(), 0);
  endtask

  task automatic randomImage();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = $urandom_range(255);
  endtask

  initial begin
    int base_done, base_writes, base_reads, cyc;
    fifo_bus.fifo_in_dout  = '0;
    fifo_bus.fifo_in_empty = 1'b1;
    fifo_bus.fifo_out_full = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("por_busy", busy, 0);
    checkOutput("por_frame_done", frame_done, 0);

    $display("[TB] flat frame, mode 0");
    foreach (img[y, x]) img[y][x] = 100;
    mode = 1'b0; threshold = 8'd0;
    doReset();
    base_done = done_count; base_writes = writes;
    applyStimulus(1'b0, 8'd0);
    waitFrames("flat", base_done + 1, base_writes + NPIX);

    $display("[TB] vertical step, mode 0");
    foreach (img[y, x]) img[y][x] = (x >= 4) ? 255 : 0;
    base_done = done_count; base_writes = writes;
    applyStimulus(1'b0, 8'd0);
    waitFrames("step_m0", base_done + 1, base_writes + NPIX);

    $display("[TB] vertical step, mode 1, threshold 200");
    mode = 1'b1; threshold = 8'd200;
    doReset();
    base_done = done_count; base_writes = writes;
    applyStimulus(1'b1, 8'd200);
    waitFrames("step_m1", base_done + 1, base_writes + NPIX);

    $display("[TB] single pixel 64, mode 1, threshold 255");
    foreach (img[y, x]) img[y][x] = 0;
    img[2][3] = 64;
    threshold = 8'd255;
    doReset();
    base_done = done_count; base_writes = writes;
    applyStimulus(1'b1, 8'd255);
    waitFrames("dot_m1", base_done + 1, base_writes + NPIX);

    $display("[TB] random frame with random stalls");
    mode = 1'b0; threshold = 8'd0;
    doReset();
    in_stall = 30; out_stall = 50;
    randomImage();
    base_done = done_count; base_writes = writes;
    applyStimulus(1'b0, 8'd0);
    waitFrames("random_stall", base_done + 1, base_writes + NPIX);
    in_stall = 0; out_stall = 0;

    $display("[TB] reset after 20 inputs");
    randomImage();
    applyStimulus(1'b0, 8'd0);
    base_reads = reads; cyc = 0;
    while (reads < base_reads + 20 && cyc < 1000) begin
      @(posedge clock);
      cyc++;
    end
    checkOutput("midreset_reads_reached", reads >= base_reads + 20, 1);
    doReset();
    randomImage();
    base_done = done_count; base_writes = writes;
    applyStimulus(1'b0, 8'd0);
    waitFrames("after_reset", base_done + 1, base_writes + NPIX);

    $display("[TB] back-to-back frames, mode switched mid-frame");
    mode = 1'b0; threshold = 8'd60;
    doReset();
    in_stall = 20; out_stall = 20;
    base_done = done_count; base_writes = writes;
    randomImage();
    applyStimulus(1'b0, 8'd60);
    randomImage();
    applyStimulus(1'b1, 8'd60);
    cyc = 0;
    while (writes < base_writes + 10 && cyc < 1000) begin
      @(posedge clock);
      cyc++;
    end
    checkOutput("b2b_first_writes_seen", writes >= base_writes + 10, 1);
    mode = 1'b1;
    waitFrames("back_to_back", base_done + 2, base_writes + 2 * NPIX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
